// File: rtl/alu_core_crc_p_pkg.sv
// Shared definitions for the parametrised ALU core and its CRC-3 engine.
package alu_core_crc_p_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_CRC    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] CRC_POLY = 3'b011;
    localparam logic [2:0] CRC_INIT = 3'b000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One MSB-first LFSR step of x^3+x+1.
    function automatic logic [2:0] crc_step(input logic [2:0] c, input logic d);
        logic fb;
        fb = d ^ c[2];
        return {c[1:0], 1'b0} ^ ({3{fb}} & CRC_POLY);
    endfunction

endpackage

// File: rtl/alu_core_crc_p_crc3.sv
// CRC-3 (x^3+x+1) over a DW-bit word, either one bit per cycle or in a single cycle.
module crc3_engine
    import alu_core_crc_p_pkg::*;
#(
    parameter int DW     = 37,
    parameter bit SERIAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] data,
    output logic          done,
    output logic [2:0]    crc
);

    localparam int CW = $clog2(DW);

    logic          running_q, running_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    crc_q, crc_d;
    logic [2:0]    crc_par;

    always_comb begin
        crc_par = CRC_INIT;
        for (int i = DW - 1; i >= 0; i--) begin
            crc_par = crc_step(crc_par, data[i]);
        end
    end

    // data must be held stable by the caller while running
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        if (start) begin
            running_d = 1'b1;
            cnt_d     = CW'(DW - 1);
            crc_d     = CRC_INIT;
        end else if (running_q) begin
            if (SERIAL) begin
                crc_d = crc_step(crc_q, data[cnt_q]);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    running_d = 1'b0;
                end
            end else begin
                crc_d     = crc_par;
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            crc_q     <= CRC_INIT;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
        end
    end

    assign done = running_q && (!SERIAL || cnt_q == '0);
    assign crc  = crc_q;

endmodule

// File: rtl/alu_core_crc_p.sv
// Parametrised ALU core: latch operands, execute, CRC the result and hold it until ack_in.
module alu_core_crc_p
    import alu_core_crc_p_pkg::*;
#(
    parameter int W          = 32,
    parameter bit CRC_SERIAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         ack_in,
    output logic         busy,
    output logic         ack,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         op_err,
    output logic [2:0]   crc
);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;
    logic         op_err_q, op_err_d;
    logic         ack_q, ack_d;

    logic [W-1:0] alu_res;
    logic [3:0]   alu_flags;
    logic         alu_legal;
    logic [W:0]   alu_ext;
    logic         crc_start, crc_done;
    logic [2:0]   crc_eng;

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        alu_legal = 1'b1;
        alu_ext   = '0;
        case (op_q)
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_ADD: begin
                alu_ext           = {1'b0, a_q} + {1'b0, b_q};
                alu_res           = alu_ext[W-1:0];
                alu_flags[FLAG_C] = alu_ext[W];
                alu_flags[FLAG_V] = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                // bit W of the widened difference is the borrow (b > a unsigned)
                alu_ext           = {1'b0, a_q} - {1'b0, b_q};
                alu_res           = alu_ext[W-1:0];
                alu_flags[FLAG_C] = alu_ext[W];
                alu_flags[FLAG_V] = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            default: alu_legal = 1'b0;
        endcase
        alu_flags[FLAG_N] = alu_res[W-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        op_err_d  = op_err_q;
        ack_d     = 1'b0;
        crc_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: state_d = S_EXEC;
            S_EXEC: begin
                if (alu_legal) begin
                    result_d  = alu_res;
                    flags_d   = alu_flags;
                    op_err_d  = 1'b0;
                    crc_start = 1'b1;
                    state_d   = S_CRC;
                end else begin
                    result_d = '0;
                    flags_d  = '0;
                    op_err_d = 1'b1;
                    state_d  = S_FINISH;
                end
            end
            S_CRC: begin
                if (crc_done) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                // ack is registered, so it rises one cycle after entering FINISH
                ack_d = 1'b1;
                if (ack_q && ack_in) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            op_err_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            op_err_q <= op_err_d;
            ack_q    <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    crc3_engine #(
        .DW     (W + 5),
        .SERIAL (CRC_SERIAL)
    ) u_crc (
        .clk   (clk),
        .rst   (rst),
        .start (crc_start),
        .data  ({result_q, 1'b1, flags_q}),
        .done  (crc_done),
        .crc   (crc_eng)
    );

    // the engine keeps its last value across an illegal op, so mask it here
    assign crc    = op_err_q ? 3'b000 : crc_eng;
    assign busy   = (state_q != S_IDLE);
    assign ack    = ack_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign op_err = op_err_q;

endmodule

// File: tb/tb_alu_core_crc_p.sv
// Bench for alu_core_crc_p: serial and parallel CRC instances driven side by side.
module tb_alu_core_crc_p;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, req, ack_in;
    logic [W-1:0] a, b;
    logic [2:0]   op;

    logic         busy_s, ack_s, op_err_s, busy_p, ack_p, op_err_p;
    logic [W-1:0] result_s, result_p;
    logic [3:0]   flags_s, flags_p;
    logic [2:0]   crc_s, crc_p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_core_crc_p #(.W(W), .CRC_SERIAL(1'b1)) dut_s (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .op(op), .ack_in(ack_in),
        .busy(busy_s), .ack(ack_s), .result(result_s), .flags(flags_s),
        .op_err(op_err_s), .crc(crc_s)
    );

    alu_core_crc_p #(.W(W), .CRC_SERIAL(1'b0)) dut_p (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .op(op), .ack_in(ack_in),
        .busy(busy_p), .ack(ack_p), .result(result_p), .flags(flags_p),
        .op_err(op_err_p), .crc(crc_p)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of {D, 000} divided by x^3+x+1 (generator 1011)
    function automatic logic [2:0] ref_crc(input logic [W-1:0] r, input logic [3:0] f);
        logic [W+7:0] v;
        v = {r, 1'b1, f, 3'b000};
        for (int i = W + 7; i >= 3; i--) begin
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        end
        return v[2:0];
    endfunction

    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic [3:0] f,
                         output logic e, output logic [2:0] c);
        longint sx, sy, ss;
        longint unsigned ux, uy;
        logic cy, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        cy = 1'b0;
        ov = 1'b0;
        e  = 1'b0;
        r  = '0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd4: begin
                r  = x + y;
                cy = (ux + uy) > 64'hFFFF_FFFF;
                ss = sx + sy;
                ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd5: begin
                r  = x - y;
                cy = uy > ux;
                ss = sx - sy;
                ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            default: e = 1'b1;
        endcase
        if (e) begin
            f = 4'b0000;
            c = 3'b000;
        end else begin
            f = {r[W-1], r == 0, cy, ov};
            c = ref_crc(r, f);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit noisy);
        logic [W-1:0] er;
        logic [3:0]   ef;
        logic         ee;
        logic [2:0]   ec;
        int lat_s, lat_p, n;
        model(o, x, y, er, ef, ee, ec);
        lat_s = 0;
        lat_p = 0;
        @(posedge clk); #1;
        req = 1'b1; a = x; b = y; op = o;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while ((lat_s == 0 || lat_p == 0) && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (ack_s && lat_s == 0) lat_s = n;
            if (ack_p && lat_p == 0) lat_p = n;
            if (noisy && n >= 1 && n <= 3) begin
                req = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom);
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
        chk({tag, " lat_s"}, W'(lat_s), ee ? W'(3) : W'(W + 8));
        chk({tag, " lat_p"}, W'(lat_p), ee ? W'(3) : W'(4));
        if (noisy) repeat (10) @(posedge clk);
        #1;
        chk({tag, " ack_s"}, W'(ack_s), W'(1));
        chk({tag, " result_s"}, result_s, er);
        chk({tag, " flags_s"}, W'(flags_s), W'(ef));
        chk({tag, " op_err_s"}, W'(op_err_s), W'(ee));
        chk({tag, " crc_s"}, W'(crc_s), W'(ec));
        chk({tag, " result_p"}, result_p, er);
        chk({tag, " flags_p"}, W'(flags_p), W'(ef));
        chk({tag, " op_err_p"}, W'(op_err_p), W'(ee));
        chk({tag, " crc_p"}, W'(crc_p), W'(ec));
        ack_in = 1'b1;
        @(posedge clk); #1;
        ack_in = 1'b0;
        chk({tag, " busy_s after ack_in"}, W'(busy_s), W'(0));
        chk({tag, " ack_s after ack_in"}, W'(ack_s), W'(0));
        chk({tag, " busy_p after ack_in"}, W'(busy_p), W'(0));
        chk({tag, " ack_p after ack_in"}, W'(ack_p), W'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy_s"}, W'(busy_s), W'(0));
        chk({tag, " ack_s"}, W'(ack_s), W'(0));
        chk({tag, " result_s"}, result_s, W'(0));
        chk({tag, " flags_s"}, W'(flags_s), W'(0));
        chk({tag, " op_err_s"}, W'(op_err_s), W'(0));
        chk({tag, " crc_s"}, W'(crc_s), W'(0));
        chk({tag, " busy_p"}, W'(busy_p), W'(0));
        chk({tag, " ack_p"}, W'(ack_p), W'(0));
        chk({tag, " result_p"}, result_p, W'(0));
        chk({tag, " crc_p"}, W'(crc_p), W'(0));
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; ack_in = 1'b0; a = '0; b = '0; op = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op("and_mask", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        chk("and_mask const", result_s, 32'h00F0_00F0);
        run_op("add_wrap", 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("add_wrap flags const", W'(flags_s), W'(4'b0110));
        run_op("sub_ovf", 3'b101, 32'h8000_0000, 32'h1, 1'b0);
        chk("sub_ovf flags const", W'(flags_p), W'(4'b0001));
        run_op("sub_borrow", 3'b101, 32'h1, 32'h2, 1'b0);
        chk("sub_borrow flags const", W'(flags_s), W'(4'b1010));
        run_op("and_zero", 3'b000, 32'h0, 32'h0, 1'b0);
        chk("and_zero crc_s const", W'(crc_s), W'(3'b110));
        chk("and_zero crc_p const", W'(crc_p), W'(3'b110));
        run_op("illegal_011", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op("or_after_err", 3'b001, 32'h1, 32'h2, 1'b0);
        chk("or_after_err const", result_p, 32'h3);
        run_op("xor_hold", 3'b010, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b1);
        run_op("illegal_110", 3'b110, 32'h5, 32'h6, 1'b0);
        run_op("illegal_111", 3'b111, 32'h7, 32'h8, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom), $urandom, $urandom, i[0]);
        end

        // asynchronous reset while the serial engine is mid-CRC
        @(posedge clk); #1;
        req = 1'b1; a = 32'h7; b = 32'h9; op = 3'b100;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_zero("mid_crc_reset");
        #1 rst = 1'b0;
        run_op("add_after_reset", 3'b100, 32'h2, 32'h3, 1'b0);
        chk("add_after_reset const", result_s, 32'h5);
        chk("add_after_reset flags const", W'(flags_s), W'(4'b0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_core_crc_p.md
Name: alu_core_crc_p

Overview:
- Parametrised successor of the team's 32-bit ALU core, used between the deserializer (operands, opcode) and the serializer (result, flags, CRC).
- Adds a generic data width and an XOR operation.
- Reports illegal opcodes through the same ack handshake instead of silently dropping them.
- CRC engine is selectable: bit-serial (small area) or single-cycle.

Parameters:
- W, 32, operand/result width (>=8).
- CRC_SERIAL, 1, 1 = CRC computed one bit per cycle; 0 = whole CRC computed in one cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  start request, sampled only in IDLE.
- a  in  W  operand A, sampled with req.
- b  in  W  operand B, sampled with req.
- op  in  3  opcode, sampled with req.
- ack_in  in  1  downstream has consumed the result.
- busy  out  1  high in every state except IDLE.
- ack  out  1  result valid; held until ack_in.
- result  out  W  operation result.
- flags  out  4  {neg, zero, carry, overflow}.
- op_err  out  1  illegal opcode flag for the current result.
- crc  out  3  CRC over {result, 1'b1, flags}.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, ack=0, result=0, flags=0, op_err=0, crc=0. Applies at any point, including mid-CRC and while ack is high; the next request starts clean.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 100 ADD, 101 SUB (a-b).
  - 011, 110, 111 are illegal.
- States: IDLE, LATCH, EXEC, CRC, FINISH (3-bit encoding).
  - IDLE: if req=1, capture a, b, op into internal registers; go to LATCH. Otherwise stay.
  - LATCH: one pipeline cycle; go to EXEC.
  - EXEC: compute and register result, flags, op_err.
    - Legal op: op_err=0; go to CRC.
    - Illegal op: result=0, flags=0, op_err=1, crc=0; go to FINISH directly.
  - CRC: polynomial x^3+x+1, init 000, data D = {result, 1'b1, flags} (W+5 bits), MSB first.
    - Serial step: fb = d ^ c[2]; c <= {c[1], c[0]^fb, fb}.
    - CRC_SERIAL=1: one bit per cycle, bit counter runs from W+4 down to 0; stay W+5 cycles.
    - CRC_SERIAL=0: unrolled loop, 1 cycle.
    - Both modes must give identical crc. Go to FINISH.
  - FINISH: ack=1 (registered, Moore). Outputs stable. If ack_in=1, go to IDLE; ack drops on the next edge.
- Latency: from the edge sampling req to ack high = 3 + L cycles, where L = W+5 (serial) or 1 (parallel). Illegal op: 3 cycles.
- req while busy is ignored. req held high continuously: a new operation starts one cycle after returning to IDLE.
- ack_in outside FINISH has no effect.
- Flags:
  - neg = result[W-1]; zero = (result==0). Valid for every legal op.
  - ADD: carry = carry-out of bit W-1; overflow = (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - SUB: carry = borrow (b > a unsigned); overflow = (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]).
  - AND/OR/XOR: carry=0, overflow=0.
- Outputs hold their last values in IDLE until the next EXEC.

Decomposition:
- Shared package holds:
  - opcode constants (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB);
  - state encodings;
  - CRC polynomial constant 3'b011 and init 3'b000;
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, crc3_engine (params DW, SERIAL; ports clk, rst, start, data[DW], done, crc[3]), reused by the serializer.

Test Plan:
- W=32, serial. AND a=0xF0F0F0F0, b=0x0FF00FF0 -> result=0x00F000F0, flags=0000, op_err=0; ack exactly 3+37=40 cycles after req.
- ADD a=0xFFFFFFFF, b=1 -> result=0, flags=0110. SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, flags=0001. SUB a=1, b=2 -> result=0xFFFFFFFF, flags=1010.
- AND a=0, b=0 -> result=0, flags=0100, crc=3'b110. Repeat with CRC_SERIAL=0 -> identical crc, ack after 4 cycles.
- op=3'b011 -> op_err=1, result=0, flags=0, crc=0, ack after 3 cycles. Next legal op (OR 1|2) -> result=3, op_err=0.
- ack_in held low 10 cycles in FINISH -> ack and outputs stable. req pulses during busy -> ignored. ack_in=1 -> IDLE next edge, busy=0.
- rst asserted mid-CRC (asynchronously, between edges) -> all outputs 0 immediately. After release, ADD 2+3 -> result=5, flags=0000.
